// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared decode constants, op/state enums and one-hot helper for alu_issue_ctrl
package alu_ctrl_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SLA  = 6'h01;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_MUL  = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;

  // Encodings double as the strobe bit index, in ALU port order.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBU = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOR  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SLL  = 4'd11,
    OP_SRA  = 4'd12,
    OP_SLA  = 4'd13,
    OP_NONE = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // OP_NONE shifts the single bit out of the 14-bit vector, yielding all zeros.
  function automatic logic [13:0] op_onehot(alu_op_e op);
    op_onehot = 14'(1) << op;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, ALU and result handshake bundle for alu_issue_ctrl
interface alu_issue_ctrl_if #(parameter int DATA_W = 32);

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic alu_add, alu_addu, alu_sub, alu_subu, alu_mul, alu_div, alu_and;
  logic alu_or, alu_xor, alu_nor, alu_srl, alu_sll, alu_sra, alu_sla;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_result;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [4:0]        res_rd;
  logic              res_illegal;

  modport master (
    input  instr_valid, instr, rs_val, rt_val, alu_result, res_ready,
    output instr_ready, alu_a, alu_b, alu_c, alu_enable,
    output alu_add, alu_addu, alu_sub, alu_subu, alu_mul, alu_div, alu_and,
    output alu_or, alu_xor, alu_nor, alu_srl, alu_sll, alu_sra, alu_sla,
    output res_valid, res_data, res_rd, res_illegal
  );

  modport slave (
    output instr_valid, instr, rs_val, rt_val, alu_result, res_ready,
    input  instr_ready, alu_a, alu_b, alu_c, alu_enable,
    input  alu_add, alu_addu, alu_sub, alu_subu, alu_mul, alu_div, alu_and,
    input  alu_or, alu_xor, alu_nor, alu_srl, alu_sll, alu_sra, alu_sla,
    input  res_valid, res_data, res_rd, res_illegal
  );

endinterface

// File: rtl/alu_issue_ctrl_decoder.sv
// rtl/alu_issue_ctrl_decoder.sv - combinational R-type op/funct to ALU operation decoder
module alu_funct_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = OP_NONE;
    illegal = 1'b0;
    if (op != 6'd0) begin
      illegal = 1'b1;
    end else begin
      case (funct)
        FUNCT_ADD:  alu_op = OP_ADD;
        FUNCT_ADDU: alu_op = OP_ADDU;
        FUNCT_SUB:  alu_op = OP_SUB;
        FUNCT_SUBU: alu_op = OP_SUBU;
        FUNCT_MUL:  alu_op = OP_MUL;
        FUNCT_DIV:  alu_op = OP_DIV;
        FUNCT_AND:  alu_op = OP_AND;
        FUNCT_OR:   alu_op = OP_OR;
        FUNCT_XOR:  alu_op = OP_XOR;
        FUNCT_NOR:  alu_op = OP_NOR;
        FUNCT_SRL:  alu_op = OP_SRL;
        FUNCT_SLL:  alu_op = OP_SLL;
        FUNCT_SRA:  alu_op = OP_SRA;
        FUNCT_SLA:  alu_op = OP_SLA;
        default:    illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one R-type op to the ALU, holds it for its latency, returns the result
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
)
(
  input  logic clk,
  input  logic rst,
  alu_issue_ctrl_if.master bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   lat_load;
  logic [13:0]        strobe;
  logic               enable;
  logic [DATA_W-1:0]  a_q, b_q, c_q, res_data_q;
  logic [4:0]         rd_q;
  logic               illegal_q, res_valid_q;
  logic               accept, finish, res_hs;
  alu_op_e            dec_op;
  logic               dec_illegal;
  logic               unused_rs_rt_fields;

  assign unused_rs_rt_fields = ^bus.instr[25:16];

  alu_funct_decoder u_dec (
    .op      (bus.instr[31:26]),
    .funct   (bus.instr[5:0]),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  always_comb begin
    lat_load = '0;
    if (dec_op == OP_MUL)      lat_load = CNT_W'(MUL_LAT - 1);
    else if (dec_op == OP_DIV) lat_load = CNT_W'(DIV_LAT - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    res_hs  = 1'b0;
    case (state)
      IDLE: if (bus.instr_valid) begin
        accept  = 1'b1;
        state_d = dec_illegal ? DONE : EXEC;
      end
      EXEC: if (cnt == '0) begin
        finish  = 1'b1;
        state_d = DONE;
      end
      DONE: if (res_valid_q && bus.res_ready) begin
        res_hs  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and enable are flops set on accept and cleared on the capture edge,
  // so they are high exactly while the FSM sits in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      strobe      <= '0;
      enable      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_data_q  <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= bus.rs_val;
        b_q        <= bus.rt_val;
        c_q        <= DATA_W'(bus.instr[10:6]);
        rd_q       <= bus.instr[15:11];
        illegal_q  <= dec_illegal;
        res_data_q <= '0;
        cnt        <= lat_load;
        if (!dec_illegal) begin
          strobe <= op_onehot(dec_op);
          enable <= 1'b1;
        end
      end
      if (state == EXEC && !finish) cnt <= cnt - CNT_W'(1);
      if (finish) begin
        res_data_q <= bus.alu_result;
        strobe     <= '0;
        enable     <= 1'b0;
      end
      res_valid_q <= (state == DONE) && !res_hs;
    end
  end

  assign bus.instr_ready = (state == IDLE) && !rst;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_c       = c_q;
  assign bus.alu_enable  = enable;
  assign bus.alu_add     = strobe[OP_ADD];
  assign bus.alu_addu    = strobe[OP_ADDU];
  assign bus.alu_sub     = strobe[OP_SUB];
  assign bus.alu_subu    = strobe[OP_SUBU];
  assign bus.alu_mul     = strobe[OP_MUL];
  assign bus.alu_div     = strobe[OP_DIV];
  assign bus.alu_and     = strobe[OP_AND];
  assign bus.alu_or      = strobe[OP_OR];
  assign bus.alu_xor     = strobe[OP_XOR];
  assign bus.alu_nor     = strobe[OP_NOR];
  assign bus.alu_srl     = strobe[OP_SRL];
  assign bus.alu_sll     = strobe[OP_SLL];
  assign bus.alu_sra     = strobe[OP_SRA];
  assign bus.alu_sla     = strobe[OP_SLA];
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_rd      = rd_q;
  assign bus.res_illegal = illegal_q;

endmodule
